// File: rtl/vid_line_prefetch_if.sv
// Memory read bus between the line prefetcher and the frame memory.
// The prefetcher is the master: it issues one burst read command at a time
// and receives the returned words in order, one per rd_data_valid beat.
//
// Signals:
//   rd_cmd_valid  master -> slave  read command request
//   rd_cmd_ready  slave  -> master command accepted when valid & ready
//   rd_cmd_addr   master -> slave  first word address of the burst
//   rd_cmd_len    master -> slave  burst length minus one
//   rd_data_valid slave  -> master one read word present (no back-pressure)
//   rd_data       slave  -> master read word, pixel RGB in [23:0]
interface vid_line_prefetch_if #(
  parameter int ADDR_W = 26
);
  logic              rd_cmd_valid;
  logic              rd_cmd_ready;
  logic [ADDR_W-1:0] rd_cmd_addr;
  logic [7:0]        rd_cmd_len;
  logic              rd_data_valid;
  logic [31:0]       rd_data;

  modport master (
    output rd_cmd_valid, rd_cmd_addr, rd_cmd_len,
    input  rd_cmd_ready, rd_data_valid, rd_data
  );

  modport slave (
    input  rd_cmd_valid, rd_cmd_addr, rd_cmd_len,
    output rd_cmd_ready, rd_data_valid, rd_data
  );
endinterface

// File: rtl/vid_line_prefetch.sv
// Ping-pong line buffer feeding the DVI transmitter from frame memory.
// While one bank is displayed, the other bank is filled with the next line
// using BURST_LEN-word read bursts. Pixels are served by hpos with a fixed
// one-cycle registered read latency. Everything runs on the pixel clock.
//
// Ports:
//   clk, rst_n      pixel clock, asynchronous active-low reset
//   frame_start     pulse before line 0; latches frame_base, fetches line 0
//   frame_base      word address of pixel (0,0)
//   preload_line    pulse before line vpos; swaps banks, fetches vpos+1
//   vpos            line index accompanying preload_line
//   hpos, active    pixel request for this cycle
//   pix_out         RGB pixel for the previous cycle's request (0 = black)
//   underrun        one-cycle pulse: the swapped-in line was incomplete
//   mem             memory read bus (master side)
module vid_line_prefetch #(
  parameter int H_RES     = 640,
  parameter int V_RES     = 480,
  parameter int BURST_LEN = 64,
  parameter int ADDR_W    = 26
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic [ADDR_W-1:0] frame_base,
  input  logic              preload_line,
  input  logic [10:0]       vpos,
  input  logic [10:0]       hpos,
  input  logic              active,
  output logic [23:0]       pix_out,
  output logic              underrun,
  vid_line_prefetch_if.master mem
);

  localparam int N_BURST = H_RES / BURST_LEN;
  localparam int PIX_W   = $clog2(H_RES);
  localparam int CNT_W   = $clog2(BURST_LEN);
  localparam int BIDX_W  = (N_BURST > 1) ? $clog2(N_BURST) : 1;

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  state_t             state, state_n;
  logic [BIDX_W-1:0]  burst_idx, burst_n;
  logic [CNT_W-1:0]   cnt;
  logic               drain, drain_n;
  logic               pend, pend_n;
  logic               load;
  logic [ADDR_W-1:0]  cmd_addr, addr_next;
  logic [ADDR_W-1:0]  base_q, base_eff;
  logic [10:0]        tgt_line, tgt_eff, new_tgt;
  logic               disp_bank;
  logic [1:0]         bank_ok;
  logic               line_valid;

  logic               fs, pl, retarget, want_new;
  logic               beat, last_beat, last_burst, line_done, ok_now, wr_en;
  logic [PIX_W-1:0]   wr_addr;
  logic [23:0]        rd_word;
  logic               unused_hi;

  logic [23:0]        bank0 [H_RES];
  logic [23:0]        bank1 [H_RES];

  assign mem.rd_cmd_valid = (state == CMD);
  assign mem.rd_cmd_addr  = cmd_addr;
  assign mem.rd_cmd_len   = 8'(BURST_LEN - 1);
  assign unused_hi        = ^mem.rd_data[31:24];

  // Event decode. frame_start has priority over a coincident preload, and
  // preloads outside the active line range are dropped entirely.
  always_comb begin
    fs         = frame_start;
    pl         = preload_line && !frame_start && (vpos < 11'(V_RES));
    retarget   = fs || pl;
    want_new   = fs || (pl && (({1'b0, vpos} + 12'd1) < 12'(V_RES)));
    new_tgt    = fs ? 11'd0 : (vpos + 11'd1);
    beat       = (state == DATA) && mem.rd_data_valid;
    last_beat  = beat && (cnt == CNT_W'(BURST_LEN - 1));
    last_burst = (burst_idx == BIDX_W'(N_BURST - 1));
    line_done  = last_beat && !drain && last_burst;
    // A line finishing in the same cycle as the swap still counts as complete.
    ok_now     = bank_ok[~disp_bank] || line_done;
    wr_en      = beat && !drain;
    wr_addr    = PIX_W'(burst_idx) * PIX_W'(BURST_LEN) + PIX_W'(cnt);
    // Command address uses the target that will be current after this edge,
    // so a fetch launched in the same cycle as the event points at the new line.
    tgt_eff    = retarget ? new_tgt : tgt_line;
    base_eff   = fs ? frame_base : base_q;
    addr_next  = base_eff + ADDR_W'(tgt_eff) * ADDR_W'(H_RES)
               + ADDR_W'(burst_n) * ADDR_W'(BURST_LEN);
  end

  // Fetch FSM next-state. A command once raised is never withdrawn or
  // changed; a retarget while busy instead lets the outstanding burst run
  // to completion with its words discarded, then restarts from burst 0.
  always_comb begin
    state_n = state;
    burst_n = burst_idx;
    drain_n = drain;
    pend_n  = pend;
    load    = 1'b0;
    unique case (state)
      IDLE: begin
        if (want_new) begin
          state_n = CMD;
          burst_n = '0;
          load    = 1'b1;
        end
      end
      CMD: begin
        if (retarget) begin
          drain_n = 1'b1;
          pend_n  = want_new;
        end
        if (mem.rd_cmd_ready) state_n = DATA;
      end
      DATA: begin
        if (retarget) begin
          drain_n = 1'b1;
          pend_n  = want_new;
        end
        if (last_beat) begin
          if (retarget || drain) begin
            drain_n = 1'b0;
            pend_n  = 1'b0;
            if (retarget ? want_new : pend) begin
              state_n = CMD;
              burst_n = '0;
              load    = 1'b1;
            end else begin
              state_n = IDLE;
            end
          end else if (last_burst) begin
            state_n = IDLE;
          end else begin
            state_n = CMD;
            burst_n = burst_idx + BIDX_W'(1);
            load    = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Control and display state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      burst_idx  <= '0;
      cnt        <= '0;
      drain      <= 1'b0;
      pend       <= 1'b0;
      cmd_addr   <= '0;
      base_q     <= '0;
      tgt_line   <= '0;
      disp_bank  <= 1'b0;
      bank_ok    <= 2'b00;
      line_valid <= 1'b0;
      underrun   <= 1'b0;
      pix_out    <= '0;
    end else begin
      state     <= state_n;
      burst_idx <= burst_n;
      drain     <= drain_n;
      pend      <= pend_n;
      if (load) cmd_addr <= addr_next;
      if ((state == CMD) && mem.rd_cmd_ready) begin
        cnt <= '0;
      end else if (beat) begin
        cnt <= last_beat ? '0 : cnt + CNT_W'(1);
      end
      if (fs) base_q <= frame_base;
      if (retarget) tgt_line <= new_tgt;

      // The old fill bank becomes the display bank; the old display bank
      // becomes the fill bank and is invalid until refetched.
      if (fs) begin
        bank_ok    <= 2'b00;
        line_valid <= 1'b0;
      end else if (pl) begin
        bank_ok[~disp_bank] <= ok_now;
        bank_ok[disp_bank]  <= 1'b0;
        line_valid          <= ok_now;
      end else if (line_done) begin
        bank_ok[~disp_bank] <= 1'b1;
      end
      if (pl) disp_bank <= ~disp_bank;
      underrun <= pl && !ok_now;

      if (active && (hpos < 11'(H_RES)) && line_valid) begin
        pix_out <= rd_word;
      end else begin
        pix_out <= '0;
      end
    end
  end

  // Bank storage: fill-side writes, display-side reads.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (disp_bank) bank0[wr_addr] <= mem.rd_data[23:0];
      else           bank1[wr_addr] <= mem.rd_data[23:0];
    end
  end

  always_comb begin
    rd_word = disp_bank ? bank1[hpos[PIX_W-1:0]] : bank0[hpos[PIX_W-1:0]];
  end

endmodule

// File: tb/tb_vid_line_prefetch.sv
// Self-checking bench for vid_line_prefetch. A memory model returns
// addr[23:0] as data with latency 5; expected command addresses and pixel
// values are queued when stimulus is driven and checked on DUT output.
module tb_vid_line_prefetch;
  localparam int ADDR_W = 26;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              frameStart = 1'b0;
  logic [ADDR_W-1:0] frameBase = '0;
  logic              preloadLine = 1'b0;
  logic [10:0]       vpos = '0;
  logic [10:0]       hpos = '0;
  logic              active = 1'b0;
  logic [23:0]       pixOut;
  logic              underrun;

  always #5 clk = ~clk;

  vid_line_prefetch_if #(.ADDR_W(ADDR_W)) bus();

  vid_line_prefetch #(
    .H_RES(640), .V_RES(480), .BURST_LEN(64), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .frame_start(frameStart), .frame_base(frameBase),
    .preload_line(preloadLine), .vpos(vpos),
    .hpos(hpos), .active(active),
    .pix_out(pixOut), .underrun(underrun),
    .mem(bus.master)
  );

  int compared = 0;
  int mismatched = 0;

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  typedef struct {
    int          cyc;
    logic [23:0] val;
    string       tag;
  } pixExp_t;

  logic [ADDR_W-1:0] expCmdQ [$];
  pixExp_t           pixQ [$];
  int                cycNow = 0;
  int                cmdCount = 0;
  int                underrunCount = 0;

  always @(posedge clk) cycNow++;

  // Memory model: one burst at a time, addr[23:0] returned as data.
  logic              memReady = 1'b1;
  bit                memBusy = 1'b0;
  int                memDelay = 0;
  int                memIdx = 0;
  logic [ADDR_W-1:0] memAddr = '0;

  initial begin
    bus.rd_cmd_ready  = 1'b1;
    bus.rd_data_valid = 1'b0;
    bus.rd_data       = '0;
    forever begin
      @(negedge clk);
      #1;
      bus.rd_cmd_ready  = memReady;
      bus.rd_data_valid = 1'b0;
      if (memBusy) begin
        if (memDelay > 0) begin
          memDelay--;
        end else begin
          bus.rd_data_valid = 1'b1;
          bus.rd_data = {8'h00, 24'(memAddr + ADDR_W'(memIdx))};
          memIdx++;
          if (memIdx == 64) memBusy = 1'b0;
        end
      end
      if (bus.rd_cmd_valid && bus.rd_cmd_ready) begin
        cmdCount++;
        checkOutput("cmdLen", 32'(bus.rd_cmd_len), 32'd63);
        if (expCmdQ.size() == 0) begin
          checkOutput("unexpectedCmd", 32'(bus.rd_cmd_addr), 32'hFFFF_FFFF);
        end else begin
          checkOutput("cmdAddr", 32'(bus.rd_cmd_addr), 32'(expCmdQ.pop_front()));
        end
        memAddr  = bus.rd_cmd_addr;
        memIdx   = 0;
        memDelay = 4;
        memBusy  = 1'b1;
      end
    end
  end

  // Pixel scoreboard: entries pushed in one cycle are due the next cycle.
  initial begin
    pixExp_t e;
    forever begin
      @(negedge clk);
      #2;
      while (pixQ.size() > 0 && pixQ[0].cyc < cycNow) begin
        e = pixQ.pop_front();
        checkOutput(e.tag, 32'(pixOut), 32'(e.val));
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (underrun === 1'b1) underrunCount++;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input string tag, input logic a, input logic [10:0] h, input logic [23:0] exp);
    pixExp_t e;
    @(negedge clk);
    active = a;
    hpos   = h;
    e.cyc = cycNow;
    e.val = exp;
    e.tag = tag;
    pixQ.push_back(e);
  endtask

  task automatic settlePixels();
    @(negedge clk);
    active = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic pulseFrameStart(input logic [ADDR_W-1:0] base);
    @(negedge clk);
    frameBase  = base;
    frameStart = 1'b1;
    @(negedge clk);
    frameStart = 1'b0;
  endtask

  task automatic pulsePreload(input logic [10:0] v);
    @(negedge clk);
    vpos        = v;
    preloadLine = 1'b1;
    @(negedge clk);
    preloadLine = 1'b0;
  endtask

  task automatic pushLine(input logic [ADDR_W-1:0] base, input int line);
    for (int k = 0; k < 10; k++) expCmdQ.push_back(base + ADDR_W'(line * 640 + k * 64));
  endtask

  task automatic waitFetchDone(input string tag);
    int n = 0;
    while ((expCmdQ.size() != 0 || memBusy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    checkOutput(tag, 32'(expCmdQ.size()), 32'd0);
  endtask

  task automatic waitCmdCount(input string tag, input int target);
    int n = 0;
    while (cmdCount < target && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, 32'(cmdCount), 32'(target));
  endtask

  initial begin
    int u0;
    int c0;

    repeat (3) @(negedge clk);
    checkOutput("rstPix", 32'(pixOut), 32'd0);
    checkOutput("rstValid", 32'(bus.rd_cmd_valid), 32'd0);
    checkOutput("rstAddr", 32'(bus.rd_cmd_addr), 32'd0);
    checkOutput("rstUnderrun", 32'(underrun), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Normal frame: line 0 fetched fully, then displayed.
    pushLine(26'h1000, 0);
    pulseFrameStart(26'h1000);
    waitFetchDone("line0Fetch");
    u0 = underrunCount;
    pushLine(26'h1000, 1);
    pulsePreload(11'd0);
    applyStimulus("l0h5", 1'b1, 11'd5, 24'h001005);
    applyStimulus("l0h0", 1'b1, 11'd0, 24'h001000);
    applyStimulus("l0h639", 1'b1, 11'd639, 24'h00127F);
    applyStimulus("l0h64", 1'b1, 11'd64, 24'h001040);
    applyStimulus("l0h640", 1'b1, 11'd640, 24'h000000);
    applyStimulus("l0inactive", 1'b0, 11'd5, 24'h000000);
    settlePixels();
    checkOutput("noUnderrunL0", 32'(underrunCount - u0), 32'd0);
    waitFetchDone("line1Fetch");

    // Command held off: valid and address must stay put.
    memReady = 1'b0;
    u0 = underrunCount;
    pulsePreload(11'd1);
    for (int i = 0; i < 20; i++) begin
      checkOutput("holdValid", 32'(bus.rd_cmd_valid), 32'd1);
      checkOutput("holdAddr", 32'(bus.rd_cmd_addr), 32'h1500);
      @(negedge clk);
    end
    checkOutput("holdNoCmd", 32'(memBusy), 32'd0);
    pushLine(26'h1000, 2);
    memReady = 1'b1;
    applyStimulus("l1h7", 1'b1, 11'd7, 24'h001287);
    settlePixels();
    checkOutput("noUnderrunL1", 32'(underrunCount - u0), 32'd0);
    waitFetchDone("line2Fetch");

    // Last line: no fetch. Out-of-range preload: nothing changes.
    c0 = cmdCount;
    u0 = underrunCount;
    pulsePreload(11'd479);
    repeat (100) @(negedge clk);
    checkOutput("noCmd479", 32'(cmdCount - c0), 32'd0);
    checkOutput("idle479", 32'(bus.rd_cmd_valid), 32'd0);
    applyStimulus("l479h9", 1'b1, 11'd9, 24'h001509);
    settlePixels();
    pulsePreload(11'd600);
    repeat (5) @(negedge clk);
    applyStimulus("l600h9", 1'b1, 11'd9, 24'h001509);
    settlePixels();
    checkOutput("noUnderrun600", 32'(underrunCount - u0), 32'd0);
    checkOutput("noCmd600", 32'(cmdCount - c0), 32'd0);

    // Early swap while line 0 is at burst 3: underrun, black line, drain, line 1.
    c0 = cmdCount;
    for (int k = 0; k < 4; k++) expCmdQ.push_back(26'h2000 + ADDR_W'(k * 64));
    pulseFrameStart(26'h2000);
    waitCmdCount("burst3Reached", c0 + 4);
    repeat (2) @(negedge clk);
    u0 = underrunCount;
    pushLine(26'h2000, 1);
    pulsePreload(11'd0);
    repeat (2) @(negedge clk);
    checkOutput("underrunPulse", 32'(underrunCount - u0), 32'd1);
    applyStimulus("blackH0", 1'b1, 11'd0, 24'h000000);
    applyStimulus("blackH5", 1'b1, 11'd5, 24'h000000);
    applyStimulus("blackH320", 1'b1, 11'd320, 24'h000000);
    applyStimulus("blackH639", 1'b1, 11'd639, 24'h000000);
    settlePixels();
    waitFetchDone("line1AfterUnderrun");
    u0 = underrunCount;
    pushLine(26'h2000, 2);
    pulsePreload(11'd1);
    applyStimulus("u1h7", 1'b1, 11'd7, 24'h002287);
    applyStimulus("u1h639", 1'b1, 11'd639, 24'h0024FF);
    settlePixels();
    checkOutput("noUnderrunU1", 32'(underrunCount - u0), 32'd0);
    waitFetchDone("line2AfterUnderrun");

    // Reset in the middle of a burst; stray beats must be ignored.
    c0 = cmdCount;
    expCmdQ.push_back(26'h3000);
    pulseFrameStart(26'h3000);
    waitCmdCount("resetBurstCmd", c0 + 1);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("postRstValid", 32'(bus.rd_cmd_valid), 32'd0);
    checkOutput("postRstAddr", 32'(bus.rd_cmd_addr), 32'd0);
    checkOutput("postRstPix", 32'(pixOut), 32'd0);
    applyStimulus("strayPix", 1'b1, 11'd7, 24'h000000);
    settlePixels();
    begin
      int n = 0;
      while (memBusy && n < 200) begin
        @(negedge clk);
        n++;
      end
    end
    repeat (5) @(negedge clk);
    checkOutput("noCmdAfterRst", 32'(cmdCount - (c0 + 1)), 32'd0);
    checkOutput("strayValid", 32'(bus.rd_cmd_valid), 32'd0);

    u0 = underrunCount;
    pushLine(26'h4000, 0);
    pulseFrameStart(26'h4000);
    waitFetchDone("line0AfterRst");
    pushLine(26'h4000, 1);
    pulsePreload(11'd0);
    applyStimulus("r0h0", 1'b1, 11'd0, 24'h004000);
    applyStimulus("r0h63", 1'b1, 11'd63, 24'h00403F);
    applyStimulus("r0h64", 1'b1, 11'd64, 24'h004040);
    applyStimulus("r0h639", 1'b1, 11'd639, 24'h00427F);
    settlePixels();
    checkOutput("noUnderrunR0", 32'(underrunCount - u0), 32'd0);
    waitFetchDone("line1AfterRst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
